// File: rtl/usb_pkt_decoder_if.sv
// rtl/usb_pkt_decoder_if.sv - UTMI receive inputs and decoded USB packet outputs
interface usb_pkt_decoder_if;
  logic        rx_active;
  logic        rx_valid;
  logic        rx_error;
  logic [7:0]  rx_byte;
  logic [3:0]  pid;
  logic        pid_valid;
  logic        pid_cks_err;
  logic [6:0]  tok_addr;
  logic [3:0]  tok_endp;
  logic [10:0] frame_no;
  logic        tok_valid;
  logic        crc5_err;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_done;
  logic        crc16_err;
  logic        seq_err;

  modport master (
    output rx_active, rx_valid, rx_error, rx_byte,
    input  pid, pid_valid, pid_cks_err, tok_addr, tok_endp, frame_no, tok_valid,
           crc5_err, rx_data, rx_data_valid, rx_data_done, crc16_err, seq_err
  );

  modport slave (
    input  rx_active, rx_valid, rx_error, rx_byte,
    output pid, pid_valid, pid_cks_err, tok_addr, tok_endp, frame_no, tok_valid,
           crc5_err, rx_data, rx_data_valid, rx_data_done, crc16_err, seq_err
  );
endinterface

// File: rtl/usb_pkt_decoder.sv
// rtl/usb_pkt_decoder.sv - USB FS receive decoder: PID check, token/SOF fields, CRC5/CRC16, payload strip
// Optional error counter enabled by USB_PKT_DECODER_ERR_CNT_EN.
module usb_pkt_decoder #(
  parameter int MAX_PAYLOAD = 1023
) (
  input  logic clk,
  input  logic rst,
`ifdef USB_PKT_DECODER_ERR_CNT_EN
  input  logic       err_cnt_clr,
  output logic [7:0] err_cnt,
`endif
  usb_pkt_decoder_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PID   = 3'd1;
  localparam logic [2:0] S_TOKEN = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_HSHK  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  localparam logic [10:0] MAX_CNT = 11'(MAX_PAYLOAD + 2);

  function automatic logic [4:0] crc5_upd(input logic [4:0] c, input logic [7:0] d, input int nbits);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 5'h14) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  logic [2:0]  state;
  logic [4:0]  crc5;
  logic [15:0] crc16;
  logic [10:0] byte_cnt;
  logic [1:0]  tok_cnt;
  logic [7:0]  tok_b1;
  logic [7:0]  d0;
  logic [7:0]  d1;

  logic        pid_phase;
  logic        abort;
  logic        eop;
  logic        pid_ok;
  logic [4:0]  crc5_fin;
  logic [15:0] crc16_nxt;
  logic [15:0] crc16_eff;
  logic [10:0] cnt_nxt;
  logic [10:0] cnt_eff;
  logic        overflow;

  always_comb begin
    // A PID byte may arrive in the same cycle rx_active rises.
    pid_phase = (state == S_PID) || ((state == S_IDLE) && bus.rx_active);
    abort     = bus.rx_active && bus.rx_error && (state != S_DRAIN);
    eop       = !bus.rx_active && (state != S_IDLE);
    pid_ok    = (bus.rx_byte[7:4] == ~bus.rx_byte[3:0]);
    crc5_fin  = crc5_upd(crc5, bus.rx_byte, 3);
    crc16_nxt = crc16_upd(crc16, bus.rx_byte);
    cnt_nxt   = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    overflow  = bus.rx_valid && (cnt_nxt > MAX_CNT);
    crc16_eff = bus.rx_valid ? crc16_nxt : crc16;
    cnt_eff   = bus.rx_valid ? cnt_nxt : byte_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= S_IDLE;
      crc5              <= 5'h1F;
      crc16             <= 16'hFFFF;
      byte_cnt          <= '0;
      tok_cnt           <= '0;
      tok_b1            <= '0;
      d0                <= '0;
      d1                <= '0;
      bus.pid           <= '0;
      bus.pid_valid     <= 1'b0;
      bus.pid_cks_err   <= 1'b0;
      bus.tok_addr      <= '0;
      bus.tok_endp      <= '0;
      bus.frame_no      <= '0;
      bus.tok_valid     <= 1'b0;
      bus.crc5_err      <= 1'b0;
      bus.rx_data       <= '0;
      bus.rx_data_valid <= 1'b0;
      bus.rx_data_done  <= 1'b0;
      bus.crc16_err     <= 1'b0;
      bus.seq_err       <= 1'b0;
    end else begin
      bus.pid_valid     <= 1'b0;
      bus.pid_cks_err   <= 1'b0;
      bus.tok_valid     <= 1'b0;
      bus.crc5_err      <= 1'b0;
      bus.rx_data_valid <= 1'b0;
      bus.rx_data_done  <= 1'b0;
      bus.crc16_err     <= 1'b0;
      bus.seq_err       <= 1'b0;
      if (abort) begin
        bus.seq_err <= 1'b1;
        state       <= S_DRAIN;
      end else begin
        case (state)
          S_IDLE, S_PID: begin
            if (bus.rx_active) state <= S_PID;
            if (pid_phase && bus.rx_valid) begin
              if (!pid_ok) begin
                bus.pid_cks_err <= 1'b1;
                state           <= S_DRAIN;
              end else begin
                bus.pid       <= bus.rx_byte[3:0];
                bus.pid_valid <= 1'b1;
                crc5          <= 5'h1F;
                crc16         <= 16'hFFFF;
                byte_cnt      <= '0;
                tok_cnt       <= '0;
                case (bus.rx_byte[3:0])
                  4'h1, 4'h9, 4'h5, 4'hD: state <= S_TOKEN;
                  4'h3, 4'hB:             state <= S_DATA;
                  4'h2, 4'hA, 4'hE:       state <= S_HSHK;
                  default:                state <= S_DRAIN;
                endcase
              end
            end
          end
          S_TOKEN: begin
            if (bus.rx_valid) begin
              case (tok_cnt)
                2'd0: begin
                  tok_b1  <= bus.rx_byte;
                  crc5    <= crc5_upd(crc5, bus.rx_byte, 8);
                  tok_cnt <= 2'd1;
                end
                2'd1: begin
                  bus.tok_addr  <= tok_b1[6:0];
                  bus.tok_endp  <= {bus.rx_byte[2:0], tok_b1[7]};
                  bus.frame_no  <= {bus.rx_byte[2:0], tok_b1};
                  bus.tok_valid <= 1'b1;
                  bus.crc5_err  <= (bus.rx_byte[7:3] != ~crc5_fin);
                  tok_cnt       <= 2'd2;
                end
                default: begin
                  bus.seq_err <= 1'b1;
                  state       <= S_DRAIN;
                end
              endcase
            end
            if (eop && ((tok_cnt == 2'd0) || ((tok_cnt == 2'd1) && !bus.rx_valid))) bus.seq_err <= 1'b1;
          end
          S_DATA: begin
            if (bus.rx_valid) begin
              crc16    <= crc16_nxt;
              byte_cnt <= cnt_nxt;
              if (overflow) begin
                bus.seq_err <= 1'b1;
                state       <= S_DRAIN;
              end else begin
                d0 <= bus.rx_byte;
                d1 <= d0;
                // The two newest bytes could be the CRC, so only older bytes leave the line.
                if (byte_cnt >= 11'd2) begin
                  bus.rx_data       <= d1;
                  bus.rx_data_valid <= 1'b1;
                end
              end
            end
            if (eop && !overflow) begin
              bus.rx_data_done <= 1'b1;
              bus.crc16_err    <= (crc16_eff != 16'hB001) || (cnt_eff < 11'd2);
            end
          end
          S_HSHK: begin
            if (bus.rx_valid) begin
              bus.seq_err <= 1'b1;
              state       <= S_DRAIN;
            end
          end
          S_DRAIN: ;
          default: state <= S_IDLE;
        endcase
        if (eop) state <= S_IDLE;
      end
    end
  end

`ifdef USB_PKT_DECODER_ERR_CNT_EN
  logic [2:0] err_inc;
  logic [8:0] err_sum;

  always_comb begin
    err_inc = 3'(bus.pid_cks_err) + 3'(bus.crc5_err) + 3'(bus.crc16_err) + 3'(bus.seq_err);
    err_sum = {1'b0, err_cnt} + 9'(err_inc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else begin
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end
`endif

endmodule
